// File: rtl/kernel2_prod_accum_if.sv
// kernel2_prod_accum_if: product input stream and result output stream of
// the kernel2 product accumulator. The slave modport is the accumulator
// side; the master modport is the producer/consumer side.
interface kernel2_prod_accum_if #(
    parameter int PROD_WIDTH = 24,
    parameter int ACC_WIDTH  = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [PROD_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  out_data;
    logic                  out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/kernel2_prod_accum.sv
// kernel2_prod_accum: sums a run-time programmed number of unsigned products
// and presents the sum plus a sticky overflow flag on a held valid/ready
// output. Optional macro KERNEL2_ACC_SAT_EN makes the accumulator saturate
// at 2^ACC_WIDTH-1 instead of wrapping; the flag is sticky in both builds.
module kernel2_prod_accum #(
    parameter int PROD_WIDTH = 24,
    parameter int ACC_WIDTH  = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    kernel2_prod_accum_if.slave  bus
);
    localparam int PAD = ACC_WIDTH + 1 - PROD_WIDTH;
    localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [LEN_WIDTH-1:0]   rem_q;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic                   ovf_q;
    logic                   busy_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [ACC_WIDTH:0]     sum_d;
    logic                   beat_d;

    // Wrap or clamp the one-bit-wider sum back to accumulator width.
    function automatic logic [ACC_WIDTH-1:0] acc_update(input logic [ACC_WIDTH:0] s);
`ifdef KERNEL2_ACC_SAT_EN
        if (s[ACC_WIDTH]) begin
            return '1;
        end
`endif
        return s[ACC_WIDTH-1:0];
    endfunction

    // Candidate sum with a carry bit, and whether a product moves this cycle.
    always_comb begin
        sum_d  = {1'b0, acc_q} + {{PAD{1'b0}}, bus.in_data};
        beat_d = bus.in_valid && in_ready_q;
    end

    // Run control FSM with registered handshake outputs and datapath state.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rem_q  <= len;
                        acc_q  <= '0;
                        ovf_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (len != '0) begin
                            state_q    <= ACCUM;
                            in_ready_q <= 1'b1;
                        end else begin
                            // Empty run: report a zero sum on the next cycle.
                            state_q     <= HOLD;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (beat_d) begin
                        acc_q <= acc_update(sum_d);
                        ovf_q <= ovf_q | sum_d[ACC_WIDTH];
                        rem_q <= rem_q - ONE;
                        if (rem_q == ONE) begin
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // acc/ovf are frozen here, so the result holds under backpressure.
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc_q;
    assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_kernel2_prod_accum.sv
// Bench for kernel2_prod_accum: a default-width instance (A) and an
// ACC_WIDTH=25 instance (B) for the overflow case. Expected results are
// queued when a run starts; per-instance monitors compare them on every
// cycle the result is presented and pop on the handshake.
module tb_kernel2_prod_accum;
    typedef struct {
        logic [31:0] data;
        logic        ovf;
    } exp_t;

    logic ap_clk;
    logic ap_rst_n;
    logic        start_a, start_b;
    logic [15:0] len_a, len_b;
    logic        busy_a, busy_b;
    int checks;
    int errors;
    int cyc;
    exp_t q_a[$];
    exp_t q_b[$];

    kernel2_prod_accum_if #(.PROD_WIDTH(24), .ACC_WIDTH(32)) bus_a ();
    kernel2_prod_accum_if #(.PROD_WIDTH(24), .ACC_WIDTH(25)) bus_b ();

    kernel2_prod_accum #(.PROD_WIDTH(24), .ACC_WIDTH(32), .LEN_WIDTH(16)) u_dut_a (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start_a), .len(len_a),
        .busy(busy_a), .bus(bus_a.slave)
    );
    kernel2_prod_accum #(.PROD_WIDTH(24), .ACC_WIDTH(25), .LEN_WIDTH(16)) u_dut_b (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start_b), .len(len_b),
        .busy(busy_b), .bus(bus_b.slave)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Present one product to A, wait (bounded) for it to be accepted.
    task automatic feed_a(input logic [23:0] d);
        int n;
        n = 0;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = d;
        while (!bus_a.in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout_a actual=%0d required=<50", n);
        end
        step();
        bus_a.in_valid = 1'b0;
        bus_a.in_data  = '0;
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        while (busy_a && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout_a actual=%0d required=<100", n);
        end
    endtask

    // Monitor A: compare whenever a result is presented, pop on handshake.
    always @(negedge ap_clk) begin
        if (bus_a.out_valid) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result_a actual=%0d required=none", bus_a.out_data);
            end else begin
                chk("out_data_a", 64'(bus_a.out_data), 64'(q_a[0].data));
                chk("out_ovf_a", 64'(bus_a.out_ovf), 64'(q_a[0].ovf));
                if (bus_a.out_ready) void'(q_a.pop_front());
            end
        end
    end

    // Monitor B: same scheme for the narrow-accumulator instance.
    always @(negedge ap_clk) begin
        if (bus_b.out_valid) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result_b actual=%0d required=none", bus_b.out_data);
            end else begin
                chk("out_data_b", 64'(bus_b.out_data), 64'(q_b[0].data));
                chk("out_ovf_b", 64'(bus_b.out_ovf), 64'(q_b[0].ovf));
                if (bus_b.out_ready) void'(q_b.pop_front());
            end
        end
    end

    initial begin
        int t0;
        checks = 0;
        errors = 0;
        cyc = 0;
        ap_rst_n = 1'b1;
        start_a = 1'b0; len_a = '0; start_b = 1'b0; len_b = '0;
        bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b1;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b1;

        // Reset values
        #3 ap_rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_in_ready", 64'(bus_a.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus_a.out_data), 64'd0);
        chk("rst_out_ovf", 64'(bus_a.out_ovf), 64'd0);
        step(); step();
        ap_rst_n = 1'b1;
        step();

        // len=4, products 1..4 back-to-back, immediate out_ready
        q_a.push_back('{data: 32'd10, ovf: 1'b0});
        start_a = 1'b1; len_a = 16'd4;
        step();
        t0 = cyc;
        start_a = 1'b0;
        chk("t1_busy", 64'(busy_a), 64'd1);
        chk("t1_in_ready", 64'(bus_a.in_ready), 64'd1);
        for (int i = 1; i <= 4; i++) feed_a(24'(i));
        chk("t1_out_valid", 64'(bus_a.out_valid), 64'd1);
        chk("t1_in_ready_hold", 64'(bus_a.in_ready), 64'd0);
        wait_idle_a();
        chk("t1_cycles", 64'(cyc - t0), 64'd5);
        chk("t1_out_valid_idle", 64'(bus_a.out_valid), 64'd0);

        // len=0: result on the next cycle, never ready for input
        q_a.push_back('{data: 32'd0, ovf: 1'b0});
        start_a = 1'b1; len_a = 16'd0;
        step();
        start_a = 1'b0;
        chk("t2_out_valid", 64'(bus_a.out_valid), 64'd1);
        chk("t2_in_ready", 64'(bus_a.in_ready), 64'd0);
        chk("t2_busy", 64'(busy_a), 64'd1);
        step();
        chk("t2_in_ready_after", 64'(bus_a.in_ready), 64'd0);
        chk("t2_busy_after", 64'(busy_a), 64'd0);

        // len=3 with gaps, stray starts, 5 cycles of backpressure
        q_a.push_back('{data: 32'd6, ovf: 1'b0});
        bus_a.out_ready = 1'b0;
        start_a = 1'b1; len_a = 16'd3;
        step();
        start_a = 1'b0;
        feed_a(24'd1);
        start_a = 1'b1; len_a = 16'd9;
        step(); step();
        start_a = 1'b0;
        feed_a(24'd2);
        step();
        feed_a(24'd3);
        start_a = 1'b1; len_a = 16'd0;
        repeat (5) begin
            chk("t3_hold_valid", 64'(bus_a.out_valid), 64'd1);
            step();
        end
        bus_a.out_ready = 1'b1;
        step();
        start_a = 1'b0;
        chk("t3_idle_busy", 64'(busy_a), 64'd0);
        chk("t3_idle_valid", 64'(bus_a.out_valid), 64'd0);
        step();
        chk("t3_no_restart", 64'(busy_a), 64'd0);

        // ACC_WIDTH=25 overflow: 3 x 16766977
`ifdef KERNEL2_ACC_SAT_EN
        q_b.push_back('{data: 32'd33554431, ovf: 1'b1});
`else
        q_b.push_back('{data: 32'd16746499, ovf: 1'b1});
`endif
        start_b = 1'b1; len_b = 16'd3;
        step();
        start_b = 1'b0;
        bus_b.in_valid = 1'b1; bus_b.in_data = 24'd16766977;
        for (int i = 0; i < 3; i++) begin
            chk("t4_in_ready", 64'(bus_b.in_ready), 64'd1);
            step();
        end
        bus_b.in_valid = 1'b0;
        chk("t4_out_valid", 64'(bus_b.out_valid), 64'd1);
        step();
        chk("t4_idle", 64'(busy_b), 64'd0);

        // Reset mid-run after 2 of 4 beats: aborted, no result
        start_a = 1'b1; len_a = 16'd4;
        step();
        start_a = 1'b0;
        feed_a(24'd100);
        feed_a(24'd200);
        #2 ap_rst_n = 1'b0;
        #1;
        chk("t5_busy", 64'(busy_a), 64'd0);
        chk("t5_in_ready", 64'(bus_a.in_ready), 64'd0);
        chk("t5_out_valid", 64'(bus_a.out_valid), 64'd0);
        chk("t5_out_data", 64'(bus_a.out_data), 64'd0);
        step();
        ap_rst_n = 1'b1;
        step();

        // Fresh run after abort: 5 + 7
        q_a.push_back('{data: 32'd12, ovf: 1'b0});
        start_a = 1'b1; len_a = 16'd2;
        step();
        start_a = 1'b0;
        feed_a(24'd5);
        feed_a(24'd7);
        chk("t6_out_valid", 64'(bus_a.out_valid), 64'd1);
        wait_idle_a();
        step();

        chk("queue_a_drained", 64'(q_a.size()), 64'd0);
        chk("queue_b_drained", 64'(q_b.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
